// File: rtl/minisys_pkg.sv
// Shared constants and types for the Minisys-1A core.
// Register file widths, init encodings and the init/run FSM states.
package minisys_pkg;

   localparam int MINISYS_DATA_W = 32;
   localparam int MINISYS_REG_AW = 5;

   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam logic [4:0] REG_RA   = 5'd31;

   localparam int RF_INIT_ZERO  = 0;
   localparam int RF_INIT_INDEX = 1;

   typedef enum logic [0:0] {
      RF_INIT = 1'b0,
      RF_RUN  = 1'b1
   } rf_state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard for regfile_mp.
// Tracks reserved registers and raises per-port stalls.
module regfile_scoreboard
   import minisys_pkg::*;
#(
   parameter int ADDR_W = MINISYS_REG_AW,
   parameter int NUM_RD = 2,
   parameter int NUM_WR = 2
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     run,
   input  logic [NUM_WR-1:0]        wr_vld,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
   input  logic                     rsv_vld,
   input  logic [ADDR_W-1:0]        rsv_addr,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   input  logic [NUM_RD-1:0]        rd_hit,
   output logic [NUM_RD-1:0]        rd_stall
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DEPTH-1:0] busy;
   logic [DEPTH-1:0] busy_nxt;

   // Set is applied after clears so a new reservation outlives the old result.
   always_comb begin
      busy_nxt = busy;
      for (int w = 0; w < NUM_WR; w++) begin
         if (wr_vld[w]) begin
            busy_nxt[wr_addr[w*ADDR_W +: ADDR_W]] = 1'b0;
         end
      end
      if (rsv_vld) begin
         busy_nxt[rsv_addr] = 1'b1;
      end
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         busy <= '0;
      end else begin
         busy <= busy_nxt;
      end
   end

   always_comb begin
      rd_stall = '0;
      for (int p = 0; p < NUM_RD; p++) begin
         rd_stall[p] = run
                     & busy[rd_addr[p*ADDR_W +: ADDR_W]]
                     & ~rd_hit[p];
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with bypass, prioritised writes,
// post-reset init sweep and pending-write scoreboard.
module regfile_mp
   import minisys_pkg::*;
#(
   parameter int DATA_W    = MINISYS_DATA_W,
   parameter int ADDR_W    = MINISYS_REG_AW,
   parameter int NUM_RD    = 2,
   parameter int NUM_WR    = 2,
   parameter int INIT_MODE = RF_INIT_INDEX
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_stall,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
   input  logic [NUM_WR*DATA_W-1:0] wr_data,
   input  logic                     rsv_en,
   input  logic [ADDR_W-1:0]        rsv_addr,
   output logic                     ready
);

   localparam int DEPTH = 2**ADDR_W;

   rf_state_e state;
   rf_state_e state_nxt;

   logic [ADDR_W:0]   cnt;
   logic [ADDR_W:0]   cnt_nxt;
   logic              run;
   logic              init_we;
   logic              init_last;
   logic [DATA_W-1:0] init_val;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [NUM_WR-1:0] wr_vld;
   logic              rsv_vld;
   logic [NUM_RD-1:0] rd_hit;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= RF_INIT;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   assign init_last = ~cnt[ADDR_W] & (&cnt[ADDR_W-1:0]);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      init_we   = 1'b0;
      unique case (state)
         RF_INIT: begin
            init_we = 1'b1;
            cnt_nxt = cnt + 1'b1;
            if (init_last) begin
               state_nxt = RF_RUN;
            end
         end
         RF_RUN: begin
            state_nxt = RF_RUN;
         end
         default: begin
            state_nxt = RF_INIT;
         end
      endcase
   end

   assign run   = (state == RF_RUN);
   assign ready = run;

   always_comb begin
      init_val = '0;
      if (INIT_MODE == RF_INIT_INDEX) begin
         init_val[ADDR_W-1:0] = cnt[ADDR_W-1:0];
      end
   end

   // Qualified writes: only in RUN, never to the zero register.
   always_comb begin
      wr_vld = '0;
      for (int w = 0; w < NUM_WR; w++) begin
         wr_vld[w] = run & wr_en[w]
                   & (wr_addr[w*ADDR_W +: ADDR_W] != '0);
      end
   end

   assign rsv_vld = run & rsv_en & (rsv_addr != '0);

   // Later ports overwrite earlier ones, giving the top index priority.
   always_ff @(posedge clock) begin
      if (init_we) begin
         mem[cnt[ADDR_W-1:0]] <= init_val;
      end
      for (int w = 0; w < NUM_WR; w++) begin
         if (wr_vld[w]) begin
            mem[wr_addr[w*ADDR_W +: ADDR_W]] <=
               wr_data[w*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin : rd_mux
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] d;
      rd_data = '0;
      rd_hit  = '0;
      ra      = '0;
      d       = '0;
      for (int p = 0; p < NUM_RD; p++) begin
         ra = rd_addr[p*ADDR_W +: ADDR_W];
         d  = mem[ra];
         for (int w = 0; w < NUM_WR; w++) begin
            if (wr_vld[w] &&
                wr_addr[w*ADDR_W +: ADDR_W] == ra) begin
               d         = wr_data[w*DATA_W +: DATA_W];
               rd_hit[p] = 1'b1;
            end
         end
         if (!run || ra == '0) begin
            d = '0;
         end
         rd_data[p*DATA_W +: DATA_W] = d;
      end
   end

   regfile_scoreboard #(
      .ADDR_W (ADDR_W),
      .NUM_RD (NUM_RD),
      .NUM_WR (NUM_WR)
   ) u_sb (
      .clock    (clock),
      .reset    (reset),
      .run      (run),
      .wr_vld   (wr_vld),
      .wr_addr  (wr_addr),
      .rsv_vld  (rsv_vld),
      .rsv_addr (rsv_addr),
      .rd_addr  (rd_addr),
      .rd_hit   (rd_hit),
      .rd_stall (rd_stall)
   );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default instance plus a
// 3-read/1-write/16-entry instance.
module tb_regfile_mp;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [9:0]  rd_addr = '0;
   logic [63:0] rd_data;
   logic [1:0]  rd_stall;
   logic [1:0]  wr_en = '0;
   logic [9:0]  wr_addr = '0;
   logic [63:0] wr_data = '0;
   logic        rsv_en = 1'b0;
   logic [4:0]  rsv_addr = '0;
   logic        ready;

   logic        reset2 = 1'b1;
   logic [11:0] rd_addr2 = '0;
   logic [95:0] rd_data2;
   logic [2:0]  rd_stall2;
   logic [0:0]  wr_en2 = '0;
   logic [3:0]  wr_addr2 = '0;
   logic [31:0] wr_data2 = '0;
   logic        rsv_en2 = 1'b0;
   logic [3:0]  rsv_addr2 = '0;
   logic        ready2;

   int total = 0;
   int bad   = 0;
   int n;

   always #5 clock = ~clock;

   regfile_mp u_dut (
      .clock    (clock),
      .reset    (reset),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_stall (rd_stall),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .ready    (ready)
   );

   regfile_mp #(
      .DATA_W (32),
      .ADDR_W (4),
      .NUM_RD (3),
      .NUM_WR (1)
   ) u_dut2 (
      .clock    (clock),
      .reset    (reset2),
      .rd_addr  (rd_addr2),
      .rd_data  (rd_data2),
      .rd_stall (rd_stall2),
      .wr_en    (wr_en2),
      .wr_addr  (wr_addr2),
      .wr_data  (wr_data2),
      .rsv_en   (rsv_en2),
      .rsv_addr (rsv_addr2),
      .ready    (ready2)
   );

   typedef struct {
      logic [1:0]  we;
      logic [4:0]  wa0;
      logic [31:0] wd0;
      logic [4:0]  wa1;
      logic [31:0] wd1;
      logic        rsv;
      logic [4:0]  rsa;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [31:0] e0;
      logic [31:0] e1;
      logic [1:0]  es;
   } vec_t;

   localparam int NV = 23;
   vec_t tv [NV];

   function automatic vec_t mk(
      input logic [1:0]  we,
      input logic [4:0]  wa0,
      input logic [31:0] wd0,
      input logic [4:0]  wa1,
      input logic [31:0] wd1,
      input logic        rsv,
      input logic [4:0]  rsa,
      input logic [4:0]  ra0,
      input logic [4:0]  ra1,
      input logic [31:0] e0,
      input logic [31:0] e1,
      input logic [1:0]  es
   );
      vec_t v;
      v.we = we;   v.wa0 = wa0; v.wd0 = wd0;
      v.wa1 = wa1; v.wd1 = wd1; v.rsv = rsv;
      v.rsa = rsa; v.ra0 = ra0; v.ra1 = ra1;
      v.e0 = e0;   v.e1 = e1;   v.es = es;
      return v;
   endfunction

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      wr_en   = '0;
      wr_addr = '0;
      wr_data = '0;
      rsv_en  = 1'b0;
      rsv_addr = '0;
   endtask

   initial begin
      tv[0]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 7, 0, 7, 0, 2'b00);
      tv[1]  = mk(2'b01, 5, 32'hDEADBEEF, 0, 0, 0, 0,
                  5, 31, 32'hDEADBEEF, 31, 2'b00);
      tv[2]  = mk(2'b00, 0, 0, 0, 0, 0, 0,
                  5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00);
      tv[3]  = mk(2'b11, 9, 32'h11, 9, 32'h22, 0, 0,
                  9, 9, 32'h22, 32'h22, 2'b00);
      tv[4]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 9, 0, 32'h22, 0, 2'b00);
      tv[5]  = mk(2'b10, 0, 0, 0, 32'hFF, 0, 0, 0, 0, 0, 0, 2'b00);
      tv[6]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 3, 0, 3, 2'b00);
      tv[7]  = mk(2'b00, 0, 0, 0, 0, 1, 12, 12, 13, 12, 13, 2'b00);
      tv[8]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 12, 12, 12, 12, 2'b11);
      tv[9]  = mk(2'b01, 12, 32'hAB, 0, 0, 0, 0,
                  12, 13, 32'hAB, 13, 2'b00);
      tv[10] = mk(2'b00, 0, 0, 0, 0, 0, 0,
                  12, 12, 32'hAB, 32'hAB, 2'b00);
      tv[11] = mk(2'b10, 0, 0, 12, 32'hCD, 1, 12,
                  12, 12, 32'hCD, 32'hCD, 2'b00);
      tv[12] = mk(2'b00, 0, 0, 0, 0, 0, 0,
                  12, 12, 32'hCD, 32'hCD, 2'b11);
      tv[13] = mk(2'b01, 12, 32'hEE, 0, 0, 0, 0,
                  12, 0, 32'hEE, 0, 2'b00);
      tv[14] = mk(2'b00, 0, 0, 0, 0, 1, 0, 12, 0, 32'hEE, 0, 2'b00);
      tv[15] = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 12, 0, 32'hEE, 2'b00);
      tv[16] = mk(2'b11, 3, 32'h33, 4, 32'h44, 0, 0,
                  3, 4, 32'h33, 32'h44, 2'b00);
      tv[17] = mk(2'b00, 0, 0, 0, 0, 0, 0,
                  3, 4, 32'h33, 32'h44, 2'b00);
      tv[18] = mk(2'b01, 6, 32'h66, 6, 32'h77, 0, 0,
                  6, 6, 32'h66, 32'h66, 2'b00);
      tv[19] = mk(2'b00, 0, 0, 0, 0, 0, 0,
                  6, 6, 32'h66, 32'h66, 2'b00);
      tv[20] = mk(2'b01, 13, 32'h77, 0, 0, 1, 12,
                  12, 13, 32'hEE, 32'h77, 2'b00);
      tv[21] = mk(2'b00, 0, 0, 0, 0, 0, 0,
                  12, 13, 32'hEE, 32'h77, 2'b01);
      tv[22] = mk(2'b10, 0, 0, 12, 32'h88, 0, 0,
                  12, 12, 32'h88, 32'h88, 2'b00);

      step();
      step();
      reset = 1'b0;
      rd_addr = {5'd0, 5'd7};
      chk("rst ready", {31'b0, ready}, 32'd0);
      chk("rst rd", rd_data[31:0], 32'd0);
      n = 0;
      while (!ready && n < 100) begin
         step();
         n++;
      end
      chk("init len", n, 32'd32);

      for (int i = 0; i < NV; i++) begin
         wr_en    = tv[i].we;
         wr_addr  = {tv[i].wa1, tv[i].wa0};
         wr_data  = {tv[i].wd1, tv[i].wd0};
         rsv_en   = tv[i].rsv;
         rsv_addr = tv[i].rsa;
         rd_addr  = {tv[i].ra1, tv[i].ra0};
         #1;
         chk($sformatf("v%0d rd0", i), rd_data[31:0], tv[i].e0);
         chk($sformatf("v%0d rd1", i), rd_data[63:32], tv[i].e1);
         chk($sformatf("v%0d st0", i), {31'b0, rd_stall[0]},
             {31'b0, tv[i].es[0]});
         chk($sformatf("v%0d st1", i), {31'b0, rd_stall[1]},
             {31'b0, tv[i].es[1]});
         step();
      end
      idle();

      rsv_en = 1'b1;
      rsv_addr = 5'd15;
      step();
      idle();
      rd_addr = {5'd0, 5'd15};
      #1;
      chk("pre-rst busy15", {31'b0, rd_stall[0]}, 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < 10; i++) step();
      chk("mid ready", {31'b0, ready}, 32'd0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      n = 0;
      while (!ready && n < 100) begin
         if (n == 5) begin
            wr_en = 2'b01;
            wr_addr = {5'd0, 5'd2};
            wr_data = {32'd0, 32'hBAD};
            rsv_en = 1'b1;
            rsv_addr = 5'd2;
         end else begin
            idle();
         end
         if (n == 20) begin
            rd_addr = {5'd15, 5'd7};
            #1;
            chk("init rd0", rd_data[31:0], 32'd0);
            chk("init st1", {31'b0, rd_stall[1]}, 32'd0);
         end
         step();
         n++;
      end
      idle();
      chk("restart len", n, 32'd32);
      rd_addr = {5'd15, 5'd2};
      #1;
      chk("post rd2", rd_data[31:0], 32'd2);
      chk("post st2", {31'b0, rd_stall[0]}, 32'd0);
      chk("post rd15", rd_data[63:32], 32'd15);
      chk("post st15", {31'b0, rd_stall[1]}, 32'd0);
      rd_addr = {5'd0, 5'd7};
      #1;
      chk("post rd7", rd_data[31:0], 32'd7);

      reset2 = 1'b0;
      chk("p2 rst ready", {31'b0, ready2}, 32'd0);
      n = 0;
      while (!ready2 && n < 100) begin
         step();
         n++;
      end
      chk("p2 init len", n, 32'd16);
      wr_en2 = 1'b1;
      wr_addr2 = 4'd6;
      wr_data2 = 32'h600DF00D;
      rd_addr2 = {4'd6, 4'd3, 4'd6};
      #1;
      chk("p2 a rd0", rd_data2[31:0], 32'h600DF00D);
      chk("p2 a rd1", rd_data2[63:32], 32'd3);
      chk("p2 a rd2", rd_data2[95:64], 32'h600DF00D);
      step();
      wr_addr2 = 4'd10;
      wr_data2 = 32'hA5;
      rd_addr2 = {4'd15, 4'd10, 4'd2};
      #1;
      chk("p2 b rd0", rd_data2[31:0], 32'd2);
      chk("p2 b rd1", rd_data2[63:32], 32'hA5);
      chk("p2 b rd2", rd_data2[95:64], 32'd15);
      step();
      wr_en2 = 1'b0;
      rd_addr2 = {4'd0, 4'd6, 4'd10};
      #1;
      chk("p2 c rd0", rd_data2[31:0], 32'hA5);
      chk("p2 c rd1", rd_data2[63:32], 32'h600DF00D);
      chk("p2 c rd2", rd_data2[95:64], 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
